// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter feeding the single write port of the 32x32 register file.
// ALU results win the port; load results wait in a small FIFO that is forced
// through after STARVE_MAX consecutive ALU grants. Loads that arrive while the
// FIFO is empty and the ALU is idle are written directly without queueing.
module regfile_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_W-1:0]             alu_reg,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_W-1:0]             mem_reg,
    input  logic [DATA_W-1:0]             mem_data,
    input  logic [ADDR_W-1:0]             query_reg,
    output logic                          query_pending,
    output logic                          regWrite,
    output logic [ADDR_W-1:0]             writeReg,
    output logic [DATA_W-1:0]             writeData,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] r_fifo_reg  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;

    logic              w_empty;
    logic              w_full;
    logic              w_force;
    logic              w_alu_xfer;
    logic              w_mem_xfer;
    logic              w_grant_alu;
    logic              w_grant_fifo;
    logic              w_grant_byp;
    logic              w_enq;
    logic              w_deq;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_query_hit;
    logic [PTR_W-1:0]  w_off;

    // The starve counter only advances while the FIFO holds data, so a forced
    // cycle always has a head entry to grant; the empty term is belt-and-braces.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_force    = !w_empty && (r_starve == STV_W'(STARVE_MAX));

    assign alu_ready  = !w_force;
    assign mem_ready  = !w_full;
    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_mem_xfer = mem_valid && mem_ready;

    assign w_grant_alu  = w_alu_xfer;
    assign w_grant_fifo = !w_alu_xfer && !w_empty;
    assign w_grant_byp  = !w_alu_xfer && w_empty && w_mem_xfer;
    assign w_enq        = w_mem_xfer && !w_grant_byp;
    assign w_deq        = w_grant_fifo;

    // Select the single winning source for this cycle's write port.
    always_comb begin
        w_grant    = 1'b0;
        w_sel_reg  = '0;
        w_sel_data = '0;
        if (w_grant_alu) begin
            w_grant    = 1'b1;
            w_sel_reg  = alu_reg;
            w_sel_data = alu_data;
        end else if (w_grant_fifo) begin
            w_grant    = 1'b1;
            w_sel_reg  = r_fifo_reg[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end else if (w_grant_byp) begin
            w_grant    = 1'b1;
            w_sel_reg  = mem_reg;
            w_sel_data = mem_data;
        end
    end

    // RAW hazard lookup: match query_reg against occupied FIFO slots only.
    always_comb begin
        w_query_hit = 1'b0;
        w_off       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) && (r_fifo_reg[i] == query_reg))
                w_query_hit = 1'b1;
        end
    end

    assign query_pending = w_query_hit && (query_reg != '0);

    // FIFO payload storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_reg[r_wr_ptr]  <= mem_reg;
            r_fifo_data[r_wr_ptr] <= mem_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count consecutive ALU wins over a waiting FIFO; any FIFO grant or an empty FIFO clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_grant_fifo || w_empty) begin
            r_starve <= '0;
        end else if (w_grant_alu) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // Register the granted write; writes to r0 are consumed without asserting regWrite.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_grant && (w_sel_reg != '0);
            if (w_grant) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
            end
        end
    end

    assign regWrite   = r_reg_write;
    assign writeReg   = r_write_reg;
    assign writeData  = r_write_data;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomized bench for regfile_writeback_arbiter against a queue-based model.
module tb_regfile_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int SMAX   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] query_reg;
    logic              query_pending;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [2:0]        fifo_count;

    regfile_writeback_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .query_reg(query_reg), .query_pending(query_pending),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];
    int   starve;
    int   n_checks;
    int   n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic              a_v, m_v;
    logic [ADDR_W-1:0] a_r, m_r;
    logic [DATA_W-1:0] a_d, m_d;
    bit                a_x, m_x;
    bit                exp_we;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_data;
    bit                reset_done;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        starve     = 0;
        reset_done = 0;
        a_v = 0; a_r = '0; a_d = '0; a_x = 0;
        m_v = 0; m_r = '0; m_d = '0; m_x = 0;
        reset     = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        query_reg = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_regWrite",  64'(regWrite), 64'd0);
        check_eq("rst_writeReg",  64'(writeReg), 64'd0);
        check_eq("rst_writeData", 64'(writeData), 64'd0);
        check_eq("rst_fifo_count", 64'(fifo_count), 64'd0);
        check_eq("rst_alu_ready", 64'(alu_ready), 64'd1);
        check_eq("rst_mem_ready", 64'(mem_ready), 64'd1);
        check_eq("rst_query",     64'(query_pending), 64'd0);
        reset = 1'b1;

        for (int it = 0; it < 900; it++) begin
            int   pa, pm;
            bit   ar, mr, qp;
            ent_t e;
            if (it < 300)      begin pa = 50; pm = 50; end
            else if (it < 600) begin pa = 95; pm = 70; end
            else               begin pa = 20; pm = 40; end

            @(negedge clk);
            if (!(a_v && !a_x)) begin
                a_v = ($urandom_range(0, 99) < pa);
                a_r = ADDR_W'($urandom_range(0, 15));
                a_d = $urandom;
            end
            if (!(m_v && !m_x)) begin
                m_v = ($urandom_range(0, 99) < pm);
                m_r = ADDR_W'($urandom_range(0, 15));
                m_d = $urandom;
            end
            alu_valid = a_v; alu_reg = a_r; alu_data = a_d;
            mem_valid = m_v; mem_reg = m_r; mem_data = m_d;
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                query_reg = q[$urandom_range(0, q.size() - 1)].r;
            else
                query_reg = ADDR_W'($urandom_range(0, 15));
            #1;

            ar = (starve != SMAX);
            mr = (q.size() != DEPTH);
            qp = 0;
            foreach (q[k]) if (q[k].r == query_reg && query_reg != 0) qp = 1;
            check_eq("alu_ready",     64'(alu_ready), 64'(ar));
            check_eq("mem_ready",     64'(mem_ready), 64'(mr));
            check_eq("fifo_count",    64'(fifo_count), 64'(q.size()));
            check_eq("query_pending", 64'(query_pending), 64'(qp));

            a_x = a_v && ar;
            m_x = m_v && mr;
            e.r = m_r;
            e.d = m_d;
            if (a_x) begin
                exp_we = (a_r != 0); exp_reg = a_r; exp_data = a_d;
                starve = (q.size() > 0) ? starve + 1 : 0;
                if (m_x) q.push_back(e);
            end else if (q.size() > 0) begin
                ent_t h;
                h = q.pop_front();
                exp_we = (h.r != 0); exp_reg = h.r; exp_data = h.d;
                starve = 0;
                if (m_x) q.push_back(e);
            end else if (m_x) begin
                exp_we = (m_r != 0); exp_reg = m_r; exp_data = m_d;
                starve = 0;
            end else begin
                exp_we = 0;
                starve = 0;
            end

            @(posedge clk);
            #1;
            check_eq("regWrite", 64'(regWrite), 64'(exp_we));
            if (exp_we) begin
                check_eq("writeReg",  64'(writeReg), 64'(exp_reg));
                check_eq("writeData", 64'(writeData), 64'(exp_data));
            end

            if (!reset_done && it >= 300 && q.size() == 3) begin
                #2;
                reset = 1'b0;
                #1;
                check_eq("async_rst_regWrite", 64'(regWrite), 64'd0);
                check_eq("async_rst_count",    64'(fifo_count), 64'd0);
                q.delete();
                starve = 0;
                a_v = 0; m_v = 0; a_x = 0; m_x = 0;
                alu_valid = 1'b0; mem_valid = 1'b0;
                query_reg = ADDR_W'(9);
                @(negedge clk);
                check_eq("rst_mid_alu_ready", 64'(alu_ready), 64'd1);
                check_eq("rst_mid_mem_ready", 64'(mem_ready), 64'd1);
                check_eq("rst_mid_query",     64'(query_pending), 64'd0);
                check_eq("rst_mid_writeReg",  64'(writeReg), 64'd0);
                check_eq("rst_mid_writeData", 64'(writeData), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                reset_done = 1;
                @(posedge clk);
                #1;
                check_eq("post_rst_regWrite", 64'(regWrite), 64'd0);
            end
        end

        check_eq("reset_exercised", 64'(reset_done), 64'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
